debug_display: RTL and testbench

DEBUG_DISPLAY -- requirements
Module: debug_display

---
 rtl/debug_display.sv | 131 +++++++++++++
 tb/tb_debug_display.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_display.sv
// Multi-channel probe viewer: selects one of NUM_CH probe words (manual, auto-cycle,
// step, or frozen snapshot) and renders it as active-low hex glyphs on DIGITS 7-segment digits.
module debug_display #(
  parameter int NUM_CH   = 8,
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 8,
  parameter int DWELL    = 50000000,
  parameter int BLANK_LZ = 0
) (
  input  logic                        iClock,
  input  logic                        iReset_n,
  input  logic [NUM_CH*WIDTH-1:0]     iProbe,
  input  logic [$clog2(NUM_CH)-1:0]   iSel,
  input  logic [1:0]                  iMode,
  input  logic                        iStep,
  input  logic                        iCapture,
  output logic [DIGITS*7-1:0]         oHex,
  output logic [$clog2(NUM_CH)-1:0]   oChannel,
  output logic                        oFrozen,
  output logic                        oSwitch
);

  localparam int SW   = $clog2(NUM_CH);
  localparam int CW   = $clog2(DWELL);
  localparam int VW   = DIGITS * 4;
  localparam int NDIG = (WIDTH + 3) / 4;

  typedef enum logic [1:0] {MANUAL, AUTO, STEP, HOLD} mode_t;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // Walk digits top-down so leading-zero blanking knows whether a nonzero nibble sits above.
  function automatic logic [DIGITS*7-1:0] encode(input logic [WIDTH-1:0] v);
    logic [VW+WIDTH-1:0] wide;
    logic [VW-1:0]       ext;
    logic [3:0]          nib;
    logic                seen;
    logic [DIGITS*7-1:0] res;
    wide = {{VW{1'b0}}, v};
    ext  = wide[VW-1:0];
    seen = 1'b0;
    res  = '1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib = ext[d*4 +: 4];
      if (nib != 4'd0) seen = 1'b1;
      if (d < NDIG && (BLANK_LZ == 0 || seen || d == 0)) res[d*7 +: 7] = glyph(nib);
      else res[d*7 +: 7] = 7'h7F;
    end
    return res;
  endfunction

  function automatic logic [DIGITS*7-1:0] reset_hex();
    logic [DIGITS*7-1:0] res;
    for (int d = 0; d < DIGITS; d++)
      res[d*7 +: 7] = (d == 0 || BLANK_LZ == 0) ? 7'h40 : 7'h7F;
    return res;
  endfunction

  localparam logic [DIGITS*7-1:0] RST_HEX = reset_hex();

  logic [WIDTH-1:0] chan [NUM_CH];
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign chan[k] = iProbe[k*WIDTH +: WIDTH];
  end

  mode_t            mode, mode_q;
  logic [SW-1:0]    idx, idx_n;
  logic [CW-1:0]    cnt, cnt_n, cnt_base;
  logic [WIDTH-1:0] snap, snap_n, disp;
  logic [31:0]      sel_ext;
  logic             step_q, cap_q, step_edge, cap_edge, mode_chg, advance;

  assign mode     = mode_t'(iMode);
  assign sel_ext  = 32'(iSel);
  assign oChannel = idx;

  always_comb begin
    mode_chg  = (mode != mode_q);
    step_edge = iStep & ~step_q;
    cap_edge  = iCapture & ~cap_q;
    cnt_base  = mode_chg ? '0 : cnt;
    idx_n     = idx;
    cnt_n     = '0;
    snap_n    = snap;
    advance   = 1'b0;
    unique case (mode)
      MANUAL: idx_n = (sel_ext >= 32'(NUM_CH)) ? SW'(NUM_CH - 1) : iSel;
      AUTO: begin
        if (cnt_base == CW'(DWELL - 1)) advance = 1'b1;
        else cnt_n = cnt_base + 1'b1;
      end
      STEP: advance = step_edge;
      HOLD: if (mode_chg || cap_edge) snap_n = chan[idx];
    endcase
    if (advance) idx_n = (idx == SW'(NUM_CH - 1)) ? '0 : idx + 1'b1;
    // Display follows the next index so oHex and oChannel update on the same edge.
    disp = (mode == HOLD) ? snap_n : chan[idx_n];
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      idx     <= '0;
      cnt     <= '0;
      snap    <= '0;
      step_q  <= 1'b0;
      cap_q   <= 1'b0;
      mode_q  <= MANUAL;
      oFrozen <= 1'b0;
      oSwitch <= 1'b0;
      oHex    <= RST_HEX;
    end else begin
      idx     <= idx_n;
      cnt     <= cnt_n;
      snap    <= snap_n;
      step_q  <= iStep;
      cap_q   <= iCapture;
      mode_q  <= mode;
      oFrozen <= (mode == HOLD);
      oSwitch <= (idx_n != idx);
      oHex    <= encode(disp);
    end
  end

endmodule

// File: tb/tb_debug_display.sv
// Directed bench for debug_display: a 32-bit/8-channel instance and a 12-bit/6-channel
// instance with leading-zero blanking, sharing clock, reset and mode controls.
module tb_debug_display;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [255:0]  probe0 = '0;
  logic [71:0]   probe1 = '0;
  logic [2:0]    sel0 = '0, sel1 = '0;
  logic [1:0]    mode = 2'd0;
  logic          step = 1'b0, capture = 1'b0;
  logic [55:0]   hex0, hex1;
  logic [2:0]    ch0, ch1;
  logic          frz0, frz1, sw0, sw1;

  int checks = 0;
  int failures = 0;

  debug_display #(.NUM_CH(8), .WIDTH(32), .DIGITS(8), .DWELL(4), .BLANK_LZ(0)) u0 (
    .iClock(clk), .iReset_n(rst_n), .iProbe(probe0), .iSel(sel0), .iMode(mode),
    .iStep(step), .iCapture(capture), .oHex(hex0), .oChannel(ch0), .oFrozen(frz0), .oSwitch(sw0));

  debug_display #(.NUM_CH(6), .WIDTH(12), .DIGITS(8), .DWELL(4), .BLANK_LZ(1)) u1 (
    .iClock(clk), .iReset_n(rst_n), .iProbe(probe1), .iSel(sel1), .iMode(mode),
    .iStep(step), .iCapture(capture), .oHex(hex1), .oChannel(ch1), .oFrozen(frz1), .oSwitch(sw1));

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [55:0] exp32(input logic [31:0] v);
    logic [55:0] r;
    for (int d = 0; d < 8; d++) r[d*7 +: 7] = seg(v[d*4 +: 4]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [31:0] v);
    probe0[k*32 +: 32] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hex0 !== {8{7'h40}} || ch0 !== 3'd0 || frz0 !== 1'b0 || sw0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_u0 hex=%h ch=%0d frz=%b sw=%b required hex=%h ch=0 frz=0 sw=0",
               hex0, ch0, frz0, sw0, {8{7'h40}});
    end
    checks++;
    if (hex1 !== {{7{7'h7F}}, 7'h40}) begin
      failures++;
      $display("FAIL reset_u1_hex got=%h required=%h", hex1, {{7{7'h7F}}, 7'h40});
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_manual();
    for (int k = 0; k < 8; k++) set_ch(k, 32'h1000_0000 * k + 32'h11 * k);
    set_ch(3, 32'h1234ABCD);
    probe1[60 +: 12] = 12'h00A;
    mode = 2'd0;
    sel0 = 3'd3;
    sel1 = 3'd7;
    tick();
    checks++;
    if (hex0 !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21} || ch0 !== 3'd3 || sw0 !== 1'b1) begin
      failures++;
      $display("FAIL manual_sel3 hex=%h ch=%0d sw=%b required hex=%h ch=3 sw=1",
               hex0, ch0, sw0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});
    end
    checks++;
    if (ch1 !== 3'd5 || hex1 !== {{7{7'h7F}}, 7'h08}) begin
      failures++;
      $display("FAIL clamp_blank ch=%0d hex=%h required ch=5 hex=%h", ch1, hex1, {{7{7'h7F}}, 7'h08});
    end
    tick();
    checks++;
    if (sw0 !== 1'b0 || ch0 !== 3'd3) begin
      failures++;
      $display("FAIL manual_switch_pulse sw=%b ch=%0d required sw=0 ch=3", sw0, ch0);
    end
  endtask

  task automatic test_auto();
    sel0 = 3'd7;
    tick();
    mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ch0 !== 3'd7 || sw0 !== 1'b0) begin
        failures++;
        $display("FAIL auto_dwell_%0d ch=%0d sw=%b required ch=7 sw=0", i, ch0, sw0);
      end
    end
    tick();
    checks++;
    if (ch0 !== 3'd0 || sw0 !== 1'b1 || hex0 !== exp32(32'h0)) begin
      failures++;
      $display("FAIL auto_wrap ch=%0d sw=%b hex=%h required ch=0 sw=1 hex=%h", ch0, sw0, hex0, exp32(32'h0));
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ch0 !== 3'd0 || sw0 !== 1'b0) begin
        failures++;
        $display("FAIL auto_second_dwell_%0d ch=%0d sw=%b required ch=0 sw=0", i, ch0, sw0);
      end
    end
    tick();
    checks++;
    if (ch0 !== 3'd1 || sw0 !== 1'b1) begin
      failures++;
      $display("FAIL auto_advance2 ch=%0d sw=%b required ch=1 sw=1", ch0, sw0);
    end
  endtask

  task automatic test_step();
    int sw_cnt = 0;
    mode = 2'd2;
    step = 1'b0;
    tick();
    checks++;
    if (ch0 !== 3'd1) begin
      failures++;
      $display("FAIL step_entry_keep ch=%0d required 1", ch0);
    end
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      sw_cnt += int'(sw0);
    end
    checks++;
    if (ch0 !== 3'd2 || sw_cnt != 1) begin
      failures++;
      $display("FAIL step_held ch=%0d switches=%0d required ch=2 switches=1", ch0, sw_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step = 1'b0;
      tick();
      sw_cnt += int'(sw0);
      step = 1'b1;
      tick();
      sw_cnt += int'(sw0);
    end
    checks++;
    if (ch0 !== 3'd5 || sw_cnt != 4) begin
      failures++;
      $display("FAIL step_toggles ch=%0d switches=%0d required ch=5 switches=4", ch0, sw_cnt);
    end
    step = 1'b0;
  endtask

  task automatic test_hold();
    mode = 2'd0;
    sel0 = 3'd2;
    set_ch(2, 32'h5);
    tick();
    mode = 2'd3;
    sel0 = 3'd6;
    tick();
    set_ch(2, 32'h9);
    tick();
    tick();
    checks++;
    if (hex0 !== exp32(32'h5) || frz0 !== 1'b1 || ch0 !== 3'd2) begin
      failures++;
      $display("FAIL hold_frozen hex=%h frz=%b ch=%0d required hex=%h frz=1 ch=2", hex0, frz0, ch0, exp32(32'h5));
    end
    capture = 1'b1;
    tick();
    checks++;
    if (hex0 !== exp32(32'h9) || frz0 !== 1'b1) begin
      failures++;
      $display("FAIL hold_capture hex=%h frz=%b required hex=%h frz=1", hex0, frz0, exp32(32'h9));
    end
    set_ch(2, 32'h7);
    tick();
    checks++;
    if (hex0 !== exp32(32'h9)) begin
      failures++;
      $display("FAIL hold_capture_held hex=%h required %h", hex0, exp32(32'h9));
    end
    capture = 1'b0;
    mode = 2'd0;
    sel0 = 3'd2;
    tick();
    checks++;
    if (frz0 !== 1'b0 || hex0 !== exp32(32'h7)) begin
      failures++;
      $display("FAIL hold_exit frz=%b hex=%h required frz=0 hex=%h", frz0, hex0, exp32(32'h7));
    end
    mode = 2'd3;
    capture = 1'b1;
    tick();
    set_ch(2, 32'hC);
    tick();
    checks++;
    if (frz0 !== 1'b1 || hex0 !== exp32(32'h7)) begin
      failures++;
      $display("FAIL hold_entry_with_capture frz=%b hex=%h required frz=1 hex=%h", frz0, hex0, exp32(32'h7));
    end
    capture = 1'b0;
    mode = 2'd0;
    tick();
  endtask

  task automatic test_reset_mid_auto();
    mode = 2'd0;
    sel0 = 3'd4;
    tick();
    mode = 2'd1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ch0 !== 3'd0 || sw0 !== 1'b0 || frz0 !== 1'b0 || hex0 !== {8{7'h40}} || hex1 !== {{7{7'h7F}}, 7'h40}) begin
      failures++;
      $display("FAIL reset_mid_auto ch=%0d sw=%b frz=%b hex0=%h hex1=%h required ch=0 sw=0 frz=0 hex0=%h hex1=%h",
               ch0, sw0, frz0, hex0, hex1, {8{7'h40}}, {{7{7'h7F}}, 7'h40});
    end
    tick();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ch0 !== 3'd0) begin
        failures++;
        $display("FAIL post_reset_dwell_%0d ch=%0d required 0", i, ch0);
      end
    end
    tick();
    checks++;
    if (ch0 !== 3'd1 || sw0 !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_advance ch=%0d sw=%b required ch=1 sw=1", ch0, sw0);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_step();
    test_hold();
    test_reset_mid_auto();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
